// File: rtl/stream_demux.sv
// One-to-NUM_CH stream demultiplexer with a single-entry output holding register.
// Routing is by in_sel (addressed mode) or by an internal round-robin pointer.
module stream_demux #(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [NUM_CH-1:0] out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [NUM_CH-1:0] out_ready,
    output logic              err
);

    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH-1);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic              r_full;
    logic [SEL_W-1:0]  r_chan;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0]  r_rr_ptr;
    logic              r_err;

    logic              w_drain;
    logic              w_accept;
    logic [SEL_W-1:0]  w_dest;
    logic              w_legal;

    // out_valid is already gated by r_full, so masking ready with it selects out_ready[chan]
    assign out_valid = r_full ? (ONE_HOT0 << r_chan) : '0;
    assign w_drain   = |(out_valid & out_ready);
    assign in_ready  = rst_n & (~r_full | w_drain);
    assign w_accept  = in_valid & in_ready;
    assign w_dest    = mode ? r_rr_ptr : in_sel;
    assign w_legal   = ({1'b0, w_dest} < NUM_CH_W);
    assign out_data  = r_data;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= 1'b0;
            r_chan   <= '0;
            r_data   <= '0;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_legal;
            if (w_accept && w_legal) begin
                r_full <= 1'b1;
                r_chan <= w_dest;
                r_data <= in_data;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
            // pointer only moves in round-robin mode, where every destination is legal
            if (w_accept && mode) begin
                r_rr_ptr <= (r_rr_ptr == LAST_CH) ? '0 : r_rr_ptr + 1'b1;
            end
        end
    end

endmodule
